// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and sync-decoder state encoding,
// used by both the decoder and the timing generator.
package vga_timing_pkg;

    localparam int DEF_H_TOTAL = 800;
    localparam int DEF_V_TOTAL = 521;
    localparam int DEF_H_PULSE = 96;
    localparam int DEF_V_PULSE = 2;
    localparam int DEF_H_BP    = 144;
    localparam int DEF_H_FP    = 784;
    localparam int DEF_V_BP    = 31;
    localparam int DEF_V_FP    = 511;

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_MAX - 1'b1;

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Video input / decoded pixel bundle between a sync source and the decoder.
interface vga_sync_decoder_if;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic [7:0]  rgb;
    logic        locked;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [7:0]  pix_rgb;
    logic        frame_start;
    logic [15:0] frame_count;
    logic        err_hlen;
    logic        err_vlen;

    modport master (
        output pix_en, hsync, vsync, rgb,
        input  locked, pix_valid, pix_x, pix_y, pix_rgb,
               frame_start, frame_count, err_hlen, err_vlen
    );

    modport slave (
        input  pix_en, hsync, vsync, rgb,
        output locked, pix_valid, pix_x, pix_y, pix_rgb,
               frame_start, frame_count, err_hlen, err_vlen
    );
endinterface

// File: rtl/sync_edge_det.sv
// Falling-edge detector for one active-low sync line, sampled only on pix_en.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync,
    output logic fall
);
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prev <= 1'b1;
        else if (pix_en)
            prev <= sync;
    end

    assign fall = pix_en & ~sync & prev;
endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from VGA hsync/vsync and tracks timing validity.
// state    | meaning
// HUNT     | waiting for a coincident hsync+vsync fall, no errors reported
// ACQUIRE  | measuring one full frame against nominal line/frame length
// LOCKED   | timing verified, pixels and frame pulses are emitted
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL,
    parameter int H_PULSE = DEF_H_PULSE,
    parameter int V_PULSE = DEF_V_PULSE,
    parameter int H_BP    = DEF_H_BP,
    parameter int H_FP    = DEF_H_FP,
    parameter int V_BP    = DEF_V_BP,
    parameter int V_FP    = DEF_V_FP
) (
    input logic               clk,
    input logic               rst,
    vga_sync_decoder_if.slave bus
);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BEG  = CNT_W'(H_BP);
    localparam logic [CNT_W-1:0] H_END  = CNT_W'(H_FP);
    localparam logic [CNT_W-1:0] V_BEG  = CNT_W'(V_BP);
    localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_FP);
    // A window overlapping the sync pulse would never be a real picture area.
    localparam bit PULSES_IN_BLANK = (H_PULSE < H_BP) && (V_PULSE < V_BP);

    logic             hfall, vfall;
    logic [1:0]       state, state_nxt;
    logic             acq_bad, acq_bad_nxt;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_cur, v_cur;
    logic             err_h, err_v, lone_v, fstart, in_win;
    logic             locked_q, pix_valid_q, frame_start_q, err_hlen_q, err_vlen_q;
    logic [CNT_W-1:0] pix_x_q, pix_y_q;
    logic [7:0]       pix_rgb_q;
    logic [15:0]      frame_count_q;

    sync_edge_det u_hs (.clk(clk), .rst(rst), .pix_en(bus.pix_en), .sync(bus.hsync), .fall(hfall));
    sync_edge_det u_vs (.clk(clk), .rst(rst), .pix_en(bus.pix_en), .sync(bus.vsync), .fall(vfall));

    // Position of the sample currently on the inputs; counters saturate at max.
    always_comb begin
        h_cur = h_cnt;
        v_cur = v_cnt;
        if (hfall)
            h_cur = '0;
        else if (h_cnt != CNT_MAX)
            h_cur = h_cnt + 1'b1;
        if (vfall)
            v_cur = '0;
        else if (hfall && v_cnt != CNT_MAX)
            v_cur = v_cnt + 1'b1;
    end

    assign lone_v = vfall && !hfall;
    assign err_h  = (state != ST_HUNT) &&
                    ((hfall && h_cnt != H_LAST) || (bus.pix_en && !hfall && h_cnt == CNT_TMO));
    assign err_v  = (state != ST_HUNT) && ((vfall && v_cnt != V_LAST) || lone_v);
    assign fstart = vfall && (state == ST_LOCKED) && !err_h && !err_v;
    assign in_win = PULSES_IN_BLANK && (state == ST_LOCKED) &&
                    (h_cur >= H_BEG) && (h_cur < H_END) &&
                    (v_cur >= V_BEG) && (v_cur < V_END);

    always_comb begin
        state_nxt   = state;
        acq_bad_nxt = acq_bad;
        case (state)
            ST_HUNT: begin
                if (hfall && vfall) begin
                    state_nxt   = ST_ACQUIRE;
                    acq_bad_nxt = 1'b0;
                end
            end
            ST_ACQUIRE: begin
                if (vfall) begin
                    if (!err_h && !err_v && !acq_bad)
                        state_nxt = ST_LOCKED;
                    acq_bad_nxt = lone_v;
                end else if (err_h) begin
                    acq_bad_nxt = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (err_h || err_v)
                    state_nxt = ST_HUNT;
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_HUNT;
            acq_bad       <= 1'b0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            locked_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            err_hlen_q    <= 1'b0;
            err_vlen_q    <= 1'b0;
        end else begin
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            err_hlen_q    <= 1'b0;
            err_vlen_q    <= 1'b0;
            if (bus.pix_en) begin
                h_cnt         <= h_cur;
                v_cnt         <= v_cur;
                state         <= state_nxt;
                acq_bad       <= acq_bad_nxt;
                locked_q      <= (state_nxt == ST_LOCKED);
                err_hlen_q    <= err_h;
                err_vlen_q    <= err_v;
                frame_start_q <= fstart;
                if (state != ST_LOCKED && state_nxt == ST_LOCKED)
                    frame_count_q <= '0;
                else if (fstart)
                    frame_count_q <= frame_count_q + 16'd1;
                if (in_win) begin
                    pix_valid_q <= 1'b1;
                    pix_x_q     <= h_cur - H_BEG;
                    pix_y_q     <= v_cur - V_BEG;
                    pix_rgb_q   <= bus.rgb;
                end
            end
        end
    end

    assign bus.locked      = locked_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_rgb     = pix_rgb_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_count = frame_count_q;
    assign bus.err_hlen    = err_hlen_q;
    assign bus.err_vlen    = err_vlen_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder using a scaled-down 40x12 raster.
module tb_vga_sync_decoder;
    localparam int HT  = 40;
    localparam int VT  = 12;
    localparam int HP  = 4;
    localparam int VP  = 2;
    localparam int HBP = 8;
    localparam int HFP = 36;
    localparam int VBP = 3;
    localparam int VFP = 11;
    localparam int ACTIVE = (HFP - HBP) * (VFP - VBP);

    localparam logic [2:0] EV_FS = 3'b001;
    localparam logic [2:0] EV_VL = 3'b010;
    localparam logic [2:0] EV_HL = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_decoder_if bus ();

    vga_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_PULSE(HP), .V_PULSE(VP),
        .H_BP(HBP), .H_FP(HFP), .V_BP(VBP), .V_FP(VFP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [27:0] pix_q[$];
    logic [2:0]  ev_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int pv_cnt   = 0;
    int pc0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One pixel strobe; expected pixel pushed when the window is active and lock is expected.
    task automatic pix(input int h, input int v, input logic hs, input logic vs,
                       input bit lk, input int gap);
        int g;
        g = (gap == 0) ? int'($urandom_range(1, 7)) : gap;
        @(negedge clk);
        bus.hsync  = hs;
        bus.vsync  = vs;
        bus.rgb    = 8'(h);
        bus.pix_en = 1'b1;
        if (lk && h >= HBP && h < HFP && v >= VBP && v < VFP)
            pix_q.push_back({10'(h - HBP), 10'(v - VBP), 8'(h)});
        @(negedge clk);
        bus.pix_en = 1'b0;
        repeat (g - 1) @(negedge clk);
    endtask

    task automatic frame(input int lines, input int short_ln, input int herr_ln,
                         input bit lk, input logic [2:0] start_ev, input int gap);
        bit lk_now;
        int len;
        lk_now = lk;
        if (start_ev != 3'b000)
            ev_q.push_back(start_ev);
        for (int v = 0; v < lines; v++) begin
            len = (v == short_ln) ? HT - 1 : HT;
            if (v == herr_ln) begin
                ev_q.push_back(EV_HL);
                lk_now = 1'b0;
            end
            for (int h = 0; h < len; h++)
                pix(h, v, (h < HP) ? 1'b0 : 1'b1, (v < VP) ? 1'b0 : 1'b1, lk_now, gap);
        end
        check("pix_queue_drained", pix_q.size(), 0);
        check("event_queue_drained", ev_q.size(), 0);
    endtask

    logic [27:0] pe;
    logic [2:0]  ee;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pix_valid) begin
                pv_cnt++;
                if (pix_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=0x%0h, required no pixel",
                             bus.pix_x, bus.pix_y, bus.pix_rgb);
                end else begin
                    pe = pix_q.pop_front();
                    check("pix_x", bus.pix_x, pe[27:18]);
                    check("pix_y", bus.pix_y, pe[17:8]);
                    check("pix_rgb", bus.pix_rgb, pe[7:0]);
                end
            end
            if (bus.err_hlen || bus.err_vlen || bus.frame_start) begin
                if (ev_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL event_unexpected: got hlen=%0b vlen=%0b fs=%0b, required none",
                             bus.err_hlen, bus.err_vlen, bus.frame_start);
                end else begin
                    ee = ev_q.pop_front();
                    check("event_code", {bus.err_hlen, bus.err_vlen, bus.frame_start}, ee);
                end
            end
        end
    end

    initial begin
        bus.pix_en = 1'b0;
        bus.hsync  = 1'b1;
        bus.vsync  = 1'b1;
        bus.rgb    = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_locked", bus.locked, 0);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_frame_count", bus.frame_count, 0);
        check("rst_errs", {bus.err_hlen, bus.err_vlen, bus.frame_start}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Lock-in: first frame enters ACQUIRE, second vsync fall locks.
        frame(VT, -1, -1, 1'b0, 3'b000, 4);
        check("locked_in_acquire", bus.locked, 0);
        frame(VT, -1, -1, 1'b1, 3'b000, 4);
        check("locked_after_2nd_vfall", bus.locked, 1);
        check("frame_count_on_lock", bus.frame_count, 0);

        // Three clean frames, the middle one with irregular strobe gaps.
        for (int f = 0; f < 3; f++) begin
            pc0 = pv_cnt;
            frame(VT, -1, -1, 1'b1, EV_FS, (f == 1) ? 0 : 4);
            check("pix_per_frame", pv_cnt - pc0, ACTIVE);
        end
        check("frame_count_3", bus.frame_count, 3);
        check("hold_pix_x", bus.pix_x, HFP - HBP - 1);
        check("hold_pix_y", bus.pix_y, VFP - VBP - 1);
        check("hold_pix_rgb", bus.pix_rgb, HFP - 1);

        // Line 5 one pixel short: err_hlen at start of line 6, back to HUNT.
        frame(VT, 5, 6, 1'b1, EV_FS, 4);
        check("short_line_unlocked", bus.locked, 0);
        check("frame_count_held", bus.frame_count, 4);
        frame(VT, -1, -1, 1'b0, 3'b000, 4);
        check("short_line_not_relocked", bus.locked, 0);
        frame(VT, -1, -1, 1'b1, 3'b000, 4);
        check("short_line_relocked", bus.locked, 1);
        check("frame_count_cleared", bus.frame_count, 0);

        // Frame of VT-1 lines: err_vlen at the following vsync fall.
        frame(VT - 1, -1, -1, 1'b1, EV_FS, 4);
        frame(VT, -1, -1, 1'b0, EV_VL, 4);
        check("short_frame_unlocked", bus.locked, 0);
        frame(VT, -1, -1, 1'b0, 3'b000, 4);
        frame(VT, -1, -1, 1'b1, 3'b000, 4);
        check("short_frame_relocked", bus.locked, 1);

        // hsync stuck high: last line ended at h=39, timeout fires when h reaches 1023.
        for (int i = 1; i <= 1100; i++) begin
            if (i == 1023 - (HT - 1))
                ev_q.push_back(EV_HL);
            pix(HT - 1 + i, VT - 1, 1'b1, 1'b1, 1'b0, 4);
        end
        check("timeout_event_seen", ev_q.size(), 0);
        check("timeout_unlocked", bus.locked, 0);
        frame(VT, -1, -1, 1'b0, 3'b000, 4);
        frame(VT, -1, -1, 1'b1, 3'b000, 4);
        check("timeout_relocked", bus.locked, 1);

        // Reset mid-line while locked and a pixel is being presented.
        frame(VT, -1, -1, 1'b1, EV_FS, 4);
        ev_q.push_back(EV_FS);
        for (int n = 0; n < 3 * HT + 20; n++)
            pix(n % HT, n / HT, (n % HT < HP) ? 1'b0 : 1'b1, (n / HT < VP) ? 1'b0 : 1'b1, 1'b1, 4);
        check("pre_rst_frame_count", bus.frame_count, 2);
        @(negedge clk);
        bus.hsync  = 1'b1;
        bus.vsync  = 1'b1;
        bus.rgb    = 8'd20;
        bus.pix_en = 1'b1;
        @(posedge clk);
        #1;
        bus.pix_en = 1'b0;
        check("pre_rst_pix_valid", bus.pix_valid, 1);
        check("pre_rst_pix_x", bus.pix_x, 20 - HBP);
        rst = 1'b1;
        #1;
        check("rst_mid_locked", bus.locked, 0);
        check("rst_mid_pix_valid", bus.pix_valid, 0);
        check("rst_mid_pix_x", bus.pix_x, 0);
        check("rst_mid_pix_y", bus.pix_y, 0);
        check("rst_mid_pix_rgb", bus.pix_rgb, 0);
        check("rst_mid_frame_count", bus.frame_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frame(VT, -1, -1, 1'b0, 3'b000, 4);
        check("rst_not_yet_locked", bus.locked, 0);
        frame(VT, -1, -1, 1'b1, 3'b000, 4);
        check("rst_relocked", bus.locked, 1);
        frame(VT, -1, -1, 1'b1, EV_FS, 4);
        check("rst_frame_count_1", bus.frame_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
